// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file and interrupt controller beside the commit stage.
// Handles csrrw/s/c, trap entry on interrupts, mret and a 64-bit mcycle counter.
module csr_irq_unit #(
  parameter int          DW           = 32,
  parameter int          ADDRW        = 12,
  parameter int          NUM_PLAT_IRQ = 4,
  parameter logic [31:0] RESET_MTVEC  = 32'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDRW-1:0]        csr_addr_i,
  input  logic [1:0]              csr_op_i,
  input  logic [DW-1:0]           csr_wdata_i,
  output logic [DW-1:0]           csr_rdata_o,
  input  logic [DW-1:0]           pc_i,
  input  logic                    instr_valid_i,
  input  logic                    is_mret_i,
  input  logic                    t_intr_i,
  input  logic                    e_intr_i,
  input  logic [NUM_PLAT_IRQ-1:0] plat_intr_i,
  output logic                    redirect_o,
  output logic [DW-1:0]           redirect_pc_o,
  output logic                    trap_o
);
  localparam logic [ADDRW-1:0] A_MSTATUS = ADDRW'(12'h300);
  localparam logic [ADDRW-1:0] A_MIE     = ADDRW'(12'h304);
  localparam logic [ADDRW-1:0] A_MTVEC   = ADDRW'(12'h305);
  localparam logic [ADDRW-1:0] A_MEPC    = ADDRW'(12'h341);
  localparam logic [ADDRW-1:0] A_MCAUSE  = ADDRW'(12'h342);
  localparam logic [ADDRW-1:0] A_MIP     = ADDRW'(12'h344);
  localparam logic [ADDRW-1:0] A_MCYCLE  = ADDRW'(12'hB00);
  localparam logic [ADDRW-1:0] A_MCYCLEH = ADDRW'(12'hB80);

  localparam logic [31:0] IRQ_MASK = 32'h0000_0880 |
                                     (((32'h1 << NUM_PLAT_IRQ) - 32'h1) << 16);

  logic        st_mie, st_mpie;
  logic [31:0] mie_q, mip_q, mtvec_q, mepc_q, mcause_q;
  logic [63:0] mcycle_q;

  logic [31:0] old_val, new_val, pend, irq_vec, tvec_base, vec_pc;
  logic [4:0]  cause;
  logic        req, mret, wr_en;

  always_comb begin
    old_val = 32'h0;
    case (csr_addr_i)
      A_MSTATUS: old_val = {19'h0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      A_MIE:     old_val = mie_q;
      A_MTVEC:   old_val = mtvec_q;
      A_MEPC:    old_val = mepc_q;
      A_MCAUSE:  old_val = mcause_q;
      A_MIP:     old_val = mip_q;
      A_MCYCLE:  old_val = mcycle_q[31:0];
      A_MCYCLEH: old_val = mcycle_q[63:32];
      default:   old_val = 32'h0;
    endcase
  end

  always_comb begin
    case (csr_op_i)
      2'b01:   new_val = csr_wdata_i;
      2'b10:   new_val = old_val | csr_wdata_i;
      2'b11:   new_val = old_val & ~csr_wdata_i;
      default: new_val = old_val;
    endcase
  end

  assign csr_rdata_o = (csr_op_i != 2'b00) ? old_val : 32'h0;

  always_comb begin
    irq_vec     = 32'h0;
    irq_vec[7]  = t_intr_i;
    irq_vec[11] = e_intr_i;
    for (int k = 0; k < NUM_PLAT_IRQ; k++) irq_vec[16+k] = plat_intr_i[k];
  end

  assign pend = mip_q & mie_q;

  // Lowest platform line scanned last so bit 16 wins among platform IRQs;
  // MEIP and MTIP override on top.
  always_comb begin
    cause = 5'd0;
    for (int k = NUM_PLAT_IRQ - 1; k >= 0; k--)
      if (pend[16+k]) cause = 5'(16 + k);
    if (pend[7])  cause = 5'd7;
    if (pend[11]) cause = 5'd11;
  end

  assign req   = st_mie & (|pend) & instr_valid_i & ~is_mret_i;
  assign mret  = instr_valid_i & is_mret_i;
  assign wr_en = instr_valid_i & (csr_op_i != 2'b00) & ~req;

  assign tvec_base = mtvec_q & 32'hFFFF_FFFC;
  assign vec_pc    = mtvec_q[0] ? tvec_base + {25'h0, cause, 2'b00} : tvec_base;

  assign trap_o        = req;
  assign redirect_o    = req | mret;
  assign redirect_pc_o = req ? vec_pc : (mret ? mepc_q : 32'h0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mie_q    <= 32'h0;
      mip_q    <= 32'h0;
      mtvec_q  <= RESET_MTVEC & 32'hFFFF_FFFD;
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
      mcycle_q <= 64'h0;
    end else begin
      mip_q <= irq_vec & IRQ_MASK;

      if (wr_en && csr_addr_i == A_MCYCLE)       mcycle_q[31:0]  <= new_val;
      else if (wr_en && csr_addr_i == A_MCYCLEH) mcycle_q[63:32] <= new_val;
      else                                       mcycle_q        <= mcycle_q + 64'h1;

      if (req) begin
        mepc_q   <= pc_i & 32'hFFFF_FFFC;
        mcause_q <= {1'b1, 26'h0, cause};
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_en && csr_addr_i == A_MSTATUS) begin
        st_mie  <= new_val[3];
        st_mpie <= new_val[7];
      end

      if (wr_en) begin
        case (csr_addr_i)
          A_MIE:    mie_q    <= new_val & IRQ_MASK;
          A_MTVEC:  mtvec_q  <= new_val & 32'hFFFF_FFFD;
          A_MEPC:   mepc_q   <= new_val & 32'hFFFF_FFFC;
          A_MCAUSE: mcause_q <= new_val;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csr_irq_unit.sv
// Self-checking bench for csr_irq_unit: vector table, directed trap/mret/mcycle
// sequences, and randomized traffic against a per-cycle reference model.
module tb_csr_irq_unit;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] csr_addr_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_wdata_i, csr_rdata_o, pc_i, redirect_pc_o;
  logic        instr_valid_i, is_mret_i, t_intr_i, e_intr_i, redirect_o, trap_o;
  logic [3:0]  plat_intr_i;

  csr_irq_unit #(.DW(32), .ADDRW(12), .NUM_PLAT_IRQ(4), .RESET_MTVEC(32'h100)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .pc_i(pc_i),
    .instr_valid_i(instr_valid_i), .is_mret_i(is_mret_i), .t_intr_i(t_intr_i),
    .e_intr_i(e_intr_i), .plat_intr_i(plat_intr_i), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .trap_o(trap_o));

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural CSR contents as plain variables.
  bit          m_mie, m_mpie;
  logic [31:0] m_ie, m_mip, m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_cyc;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h304: return m_ie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_req(output int cause);
    int prio[6] = '{11, 7, 16, 17, 18, 19};
    logic [31:0] p = m_mip & m_ie;
    cause = 0;
    for (int i = 5; i >= 0; i--) if (p[prio[i]]) cause = prio[i];
    return m_mie && (p != 0) && instr_valid_i && !is_mret_i;
  endfunction

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_ie = 0; m_mip = 0;
    m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_cyc = 0;
  endtask

  task automatic m_edge();
    int c;
    bit rq = m_req(c);
    logic [31:0] old = m_read(csr_addr_i);
    logic [31:0] nv = (csr_op_i == 2'd1) ? csr_wdata_i :
                      (csr_op_i == 2'd2) ? (old | csr_wdata_i) : (old & ~csr_wdata_i);
    bit wr = instr_valid_i && csr_op_i != 0 && !rq;
    if (wr && csr_addr_i == 12'hB00)      m_cyc[31:0] = nv;
    else if (wr && csr_addr_i == 12'hB80) m_cyc[63:32] = nv;
    else                                  m_cyc = m_cyc + 1;
    if (rq) begin
      m_mepc = {pc_i[31:2], 2'b00};
      m_mcause = 32'h8000_0000 + 32'(c);
      m_mpie = m_mie; m_mie = 0;
    end else if (instr_valid_i && is_mret_i) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (wr) begin
      case (csr_addr_i)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_ie = nv & 32'h000F_0880;
        12'h305: m_mtvec = nv & 32'hFFFF_FFFD;
        12'h341: m_mepc = nv & 32'hFFFF_FFFC;
        12'h342: m_mcause = nv;
        default: ;
      endcase
    end
    m_mip = (32'(plat_intr_i) << 16) | (32'(e_intr_i) << 11) | (32'(t_intr_i) << 7);
  endtask

  logic [31:0] s_rd, s_rpc;
  logic        s_tr, s_rdr;

  // One commit cycle: drive, compare against the model, clock, advance model.
  task automatic step(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                      input logic [31:0] pc, input bit v, input bit mr);
    int c;
    bit rq;
    logic [31:0] epc;
    csr_addr_i = a; csr_op_i = op; csr_wdata_i = wd; pc_i = pc;
    instr_valid_i = v; is_mret_i = mr;
    #1;
    rq = m_req(c);
    if (rq) epc = (m_mtvec & 32'hFFFF_FFFC) + (m_mtvec[0] ? 32'(c) * 4 : 32'h0);
    else if (v && mr) epc = m_mepc;
    else epc = 32'h0;
    s_rd = csr_rdata_o; s_tr = trap_o; s_rdr = redirect_o; s_rpc = redirect_pc_o;
    chk("model_rdata", s_rd, (op != 0) ? m_read(a) : 32'h0);
    chk("model_trap", 32'(s_tr), 32'(rq));
    chk("model_redirect", 32'(s_rdr), 32'(rq || (v && mr)));
    chk("model_redirect_pc", s_rpc, epc);
    @(posedge clk_i);
    m_edge();
    @(negedge clk_i);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    step(a, 2'd2, 32'h0, 32'h0, 1'b1, 1'b0);
    chk(name, s_rd, exp);
  endtask

  typedef struct {
    logic [11:0] a;
    logic [1:0]  op;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[16];

  logic [11:0] addr_pool[10];

  initial begin
    tbl[0]  = '{12'h304, 2'd1, 32'h0000_0880, 32'h0000_0000};
    tbl[1]  = '{12'h300, 2'd2, 32'h0000_0008, 32'h0000_1800};
    tbl[2]  = '{12'h300, 2'd3, 32'h0000_0008, 32'h0000_1808};
    tbl[3]  = '{12'h304, 2'd2, 32'h0000_0000, 32'h0000_0880};
    tbl[4]  = '{12'h305, 2'd1, 32'h0000_0203, 32'h0000_0100};
    tbl[5]  = '{12'h305, 2'd2, 32'h0000_0000, 32'h0000_0201};
    tbl[6]  = '{12'h341, 2'd1, 32'h0000_0043, 32'h0000_0000};
    tbl[7]  = '{12'h341, 2'd2, 32'h0000_0000, 32'h0000_0040};
    tbl[8]  = '{12'h300, 2'd1, 32'hFFFF_FFFF, 32'h0000_1800};
    tbl[9]  = '{12'h300, 2'd3, 32'hFFFF_FFFF, 32'h0000_1888};
    tbl[10] = '{12'h342, 2'd1, 32'h1234_5678, 32'h0000_0000};
    tbl[11] = '{12'h342, 2'd3, 32'h0000_0000, 32'h1234_5678};
    tbl[12] = '{12'h123, 2'd1, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[13] = '{12'h123, 2'd2, 32'h0000_0000, 32'h0000_0000};
    tbl[14] = '{12'h304, 2'd1, 32'hFFFF_FFFF, 32'h0000_0880};
    tbl[15] = '{12'h304, 2'd1, 32'h0000_0000, 32'h000F_0880};
    addr_pool = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                  12'hB00, 12'hB80, 12'h123, 12'h7C0};

    // Reset state
    rst_i = 1'b1; csr_addr_i = 12'h300; csr_op_i = 2'd0; csr_wdata_i = 0; pc_i = 0;
    instr_valid_i = 0; is_mret_i = 0; t_intr_i = 0; e_intr_i = 0; plat_intr_i = 0;
    m_reset();
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_rdata_noop", csr_rdata_o, 32'h0);
    chk("reset_redirect", 32'(redirect_o), 32'h0);
    chk("reset_trap", 32'(trap_o), 32'h0);
    chk("reset_redirect_pc", redirect_pc_o, 32'h0);
    csr_op_i = 2'd2; #1;
    chk("reset_mstatus", csr_rdata_o, 32'h1800);
    csr_addr_i = 12'h305; #1;
    chk("reset_mtvec", csr_rdata_o, 32'h100);
    csr_op_i = 2'd0;
    @(negedge clk_i);
    rst_i = 1'b0;

    // Table-driven CSR access vectors
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].a, tbl[i].op, tbl[i].wd, 32'h0, 1'b1, 1'b0);
      chk($sformatf("tbl_%0d_rdata", i), s_rd, tbl[i].exp);
    end

    // Timer interrupt, vectored mtvec 0x201, trap at pc 0x40
    step(12'h304, 2'd1, 32'h80, 32'h0, 1'b1, 1'b0);
    step(12'h300, 2'd2, 32'h8, 32'h0, 1'b1, 1'b0);
    t_intr_i = 1'b1;
    step(12'h000, 2'd0, 32'h0, 32'h40, 1'b1, 1'b0);
    chk("tmr_no_trap_before_sync", 32'(s_tr), 32'h0);
    step(12'h000, 2'd0, 32'h0, 32'h40, 1'b1, 1'b0);
    chk("tmr_trap", 32'(s_tr), 32'h1);
    chk("tmr_redirect", 32'(s_rdr), 32'h1);
    chk("tmr_vec_pc", s_rpc, 32'h21C);
    rd(12'h341, 32'h40, "tmr_mepc");
    rd(12'h342, 32'h8000_0007, "tmr_mcause");
    rd(12'h300, 32'h1880, "tmr_mstatus");
    step(12'h000, 2'd0, 32'h0, 32'h50, 1'b1, 1'b1);
    chk("mret_redirect", 32'(s_rdr), 32'h1);
    chk("mret_pc", s_rpc, 32'h40);
    chk("mret_no_trap", 32'(s_tr), 32'h0);
    step(12'h300, 2'd2, 32'h0, 32'h40, 1'b1, 1'b0);
    chk("retake_trap", 32'(s_tr), 32'h1);
    chk("retake_mstatus_mie1", s_rd, 32'h1888);

    // Priority with all sources enabled; squashed csrrw
    step(12'h304, 2'd1, 32'h000F_0880, 32'h0, 1'b1, 1'b0);
    e_intr_i = 1'b1; plat_intr_i = 4'h1;
    step(12'h000, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(12'h300, 2'd2, 32'h8, 32'h0, 1'b1, 1'b0);
    step(12'h305, 2'd1, 32'h999, 32'h80, 1'b1, 1'b0);
    chk("prio_trap", 32'(s_tr), 32'h1);
    chk("prio_vec_pc", s_rpc, 32'h22C);
    rd(12'h342, 32'h8000_000B, "prio_mcause");
    rd(12'h305, 32'h201, "squashed_write_mtvec");

    // mip read-only, mcycle wrap
    e_intr_i = 1'b0; plat_intr_i = 4'h0;
    step(12'h000, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(12'h344, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    chk("mip_old", s_rd, 32'h80);
    rd(12'h344, 32'h80, "mip_unchanged");
    t_intr_i = 1'b0;
    step(12'hB00, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    step(12'hB80, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    step(12'h000, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    rd(12'hB00, 32'h0, "mcycle_wrap_lo");
    rd(12'hB80, 32'h0, "mcycle_wrap_hi");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit v = ($urandom_range(0, 9) < 8);
      bit mr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) t_intr_i = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) e_intr_i = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) plat_intr_i = 4'($urandom_range(0, 15));
      step(addr_pool[$urandom_range(0, 9)], mr ? 2'd0 : 2'($urandom_range(0, 3)),
           $urandom, $urandom, v, mr);
    end

    // Asynchronous reset while a trap is being requested
    t_intr_i = 1'b1; e_intr_i = 1'b0; plat_intr_i = 4'h0;
    step(12'h304, 2'd1, 32'h80, 32'h0, 1'b1, 1'b0);
    step(12'h305, 2'd1, 32'h0, 32'h0, 1'b1, 1'b0);
    step(12'h300, 2'd1, 32'h8, 32'h0, 1'b1, 1'b0);
    csr_op_i = 2'd0; instr_valid_i = 1'b1; is_mret_i = 1'b0; pc_i = 32'h60;
    #1;
    chk("midtrap_redirect_before_rst", 32'(redirect_o), 32'h1);
    #1 rst_i = 1'b1;
    #1;
    chk("midtrap_redirect_in_rst", 32'(redirect_o), 32'h0);
    chk("midtrap_trap_in_rst", 32'(trap_o), 32'h0);
    csr_addr_i = 12'h300; csr_op_i = 2'd2; #1;
    chk("midtrap_mstatus_cleared", csr_rdata_o, 32'h1800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_irq_unit.md
Name: csr_irq_unit

Overview:
- Parametrised machine-mode CSR file and interrupt controller for the 3-stage core.
- Supports csrrw/csrrs/csrrc semantics, a configurable number of platform interrupt lines, direct/vectored mtvec, trap entry/exit (mret) and a 64-bit mcycle counter.
- Sits beside the execute/commit stage; drives a PC redirect into fetch on trap or mret.

Parameters:
- DW, 32, data width; only 32 supported.
- ADDRW, 12, CSR address width.
- NUM_PLAT_IRQ, 4, platform interrupt lines mapped to mip/mie bits 16..16+NUM_PLAT_IRQ-1; legal range 0..16.
- RESET_MTVEC, 32'h0, reset value of mtvec.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- csr_addr_i  in  ADDRW  CSR address.
- csr_op_i  in  2  00 none, 01 write, 10 set, 11 clear.
- csr_wdata_i  in  DW  rs1/uimm operand.
- csr_rdata_o  out  DW  old CSR value; combinational.
- pc_i  in  DW  PC of the instruction currently at commit.
- instr_valid_i  in  1  commit slot holds a valid instruction.
- is_mret_i  in  1  committing instruction is mret.
- t_intr_i  in  1  timer interrupt, level.
- e_intr_i  in  1  external interrupt, level.
- plat_intr_i  in  NUM_PLAT_IRQ  platform interrupts, level.
- redirect_o  out  1  fetch redirect; combinational.
- redirect_pc_o  out  DW  redirect target.
- trap_o  out  1  interrupt taken this cycle; squashes the commit instruction.

Behaviour:
- **Implemented CSRs:**
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP bits12:11 read 2'b11; other bits 0.
  - mie 0x304 and mip 0x344: bits 7, 11, 16+.
  - mtvec 0x305: bit0 is mode, 0 direct, 1 vectored; bit1 reads 0.
  - mepc 0x341: bits1:0 read 0.
  - mcause 0x342.
  - mcycle 0xB00 and mcycleh 0xB80.
  - Any other address reads 0 and ignores writes.
- **Reset values:**
  - All CSRs 0, except mtvec = RESET_MTVEC and mstatus.MPP = 2'b11.
  - Outputs redirect_o=0, trap_o=0, redirect_pc_o=0, csr_rdata_o=0 (no op).
- **Read:** csr_rdata_o returns the pre-update value whenever csr_op_i != 00, otherwise 0.
- **Write:** when instr_valid_i and op != 00 and no trap, new value is one of:
  - wdata (write)
  - old | wdata (set)
  - old & ~wdata (clear)
  - Read-only bits and unimplemented bits are masked.
- **mip:**
  - Read-only; writes are ignored.
  - Each rising edge, mip[7]<=t_intr_i, mip[11]<=e_intr_i, mip[16+k]<=plat_intr_i[k]; one-cycle registration latency.
- **Interrupt request:**
  - pend = mip & mie; req = mstatus.MIE & |pend & instr_valid_i & ~is_mret_i.
  - Priority is MEIP(11), then MTIP(7), then platform bit 16 (highest platform) to bit 16+N-1.
- **Trap entry (req=1), same cycle:**
  - trap_o=1, redirect_o=1.
  - redirect_pc_o = mtvec base (bits31:2, bits1:0=0) in direct mode, or base + 4*cause in vectored mode.
- **Trap entry, at the edge:**
  - mepc<=pc_i, mcause<={1'b1, 31-bit cause}.
  - MPIE<=MIE, MIE<=0.
  - Any CSR write from the squashed instruction is dropped.
- **mret (instr_valid_i & is_mret_i):**
  - redirect_o=1, redirect_pc_o=mepc, trap_o=0.
  - At the edge MIE<=MPIE, MPIE<=1.
  - Pending interrupts are evaluated from the next cycle.
- **mcycle:**
  - 64-bit counter, increments every cycle and wraps 2^64-1 to 0.
  - A CSR write to either half replaces that half, and the counter does not increment that cycle.
- **Reset mid-trap:** asynchronous reset clears all state immediately; redirect_o drops within the reset assertion.

Test Plan:
- Reset with mtvec RESET_MTVEC=0x100 → mstatus reads 0x1800, mtvec 0x100, redirect_o=0.
- csrrw mie←0x880, csrrs mstatus←0x8, csrrc mstatus←0x8 → reads return old values 0x0 / 0x1800 / 0x1808 respectively.
- MIE=1, mie=0x80, mtvec=0x201 (vectored), raise t_intr_i at pc 0x40:
  - One cycle later trap_o=1, redirect_pc_o=0x21C.
  - mepc=0x40, mcause=0x80000007, MIE=0, MPIE=1.
- Simultaneous e_intr_i, t_intr_i and plat_intr_i[0] with all enabled → mcause=0x8000000B; a csrrw in the trap cycle has no effect.
- mret after trap → redirect_pc_o=0x40, MIE=1; with t_intr still pending, trap is retaken exactly one cycle later.
- Write mcycle=0xFFFFFFFF, mcycleh=0xFFFFFFFF → one cycle after the last write both halves read 0 (wrap); a write to mip leaves mip unchanged.
